// File: rtl/sha256_msg_ctrl_if.sv
// rtl/sha256_msg_ctrl_if.sv - byte-stream and core handshake bundle for sha256_msg_ctrl (option: SHA256_MSG_CTRL_ABORT_EN)
interface sha256_msg_ctrl_if;
  logic [7:0]   i_byte;
  logic         i_valid;
  logic         o_ready;
  logic         i_eom;
  logic [511:0] o_blk;
  logic         o_core_start;
  logic         o_core_init;
  logic         i_core_done;
  logic         o_busy;
  logic         o_msg_done;
`ifdef SHA256_MSG_CTRL_ABORT_EN
  logic         i_abort;

  modport master (
    output i_byte, i_valid, i_eom, i_core_done, i_abort,
    input  o_ready, o_blk, o_core_start, o_core_init, o_busy, o_msg_done
  );

  modport slave (
    input  i_byte, i_valid, i_eom, i_core_done, i_abort,
    output o_ready, o_blk, o_core_start, o_core_init, o_busy, o_msg_done
  );
`else
  modport master (
    output i_byte, i_valid, i_eom, i_core_done,
    input  o_ready, o_blk, o_core_start, o_core_init, o_busy, o_msg_done
  );

  modport slave (
    input  i_byte, i_valid, i_eom, i_core_done,
    output o_ready, o_blk, o_core_start, o_core_init, o_busy, o_msg_done
  );
`endif
endinterface

// File: rtl/sha256_msg_ctrl.sv
// rtl/sha256_msg_ctrl.sv - SHA-256 message padding, length append and block sequencer (option: SHA256_MSG_CTRL_ABORT_EN)
module sha256_msg_ctrl #(
  parameter int LEN_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  sha256_msg_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, SEND, WAIT, DONE} state_t;

  state_t           state;
  // Block buffer doubles as the o_blk register; element 63 is byte 0 (MSB).
  logic [63:0][7:0] buffer;
  logic [6:0]       idx;
  logic [LEN_W-1:0] bitcnt;
  logic             first;
  logic             eom_seen;
  logic             last;
  logic             pad80_done;
  logic             ready;
  logic             busy;
  logic             core_start;
  logic             core_init;
  logic             msg_done;
  logic             accept;
  logic [5:0]       wr_sel;

  assign accept = bus.i_valid & ready;
  // Byte position idx maps to packed element 63-idx so byte 0 lands in [511:504].
  assign wr_sel = 6'd63 - idx[5:0];

  assign bus.o_ready      = ready;
  assign bus.o_blk        = buffer;
  assign bus.o_core_start = core_start;
  assign bus.o_core_init  = core_init;
  assign bus.o_busy       = busy;
  assign bus.o_msg_done   = msg_done;

  // Message sequencer: fill, pad, append length, issue block, wait for the core.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      buffer     <= '0;
      idx        <= '0;
      bitcnt     <= '0;
      first      <= 1'b1;
      eom_seen   <= 1'b0;
      last       <= 1'b0;
      pad80_done <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      core_start <= 1'b0;
      core_init  <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      ready      <= 1'b0;
      core_start <= 1'b0;
      msg_done   <= 1'b0;
`ifdef SHA256_MSG_CTRL_ABORT_EN
      if (bus.i_abort && state != IDLE) begin
        state      <= IDLE;
        idx        <= '0;
        bitcnt     <= '0;
        first      <= 1'b1;
        eom_seen   <= 1'b0;
        last       <= 1'b0;
        pad80_done <= 1'b0;
        ready      <= 1'b1;
        busy       <= 1'b0;
      end else
`else
      // Without the abort option only reset can cancel a message.
`endif
      begin
        case (state)
          IDLE: begin
            ready <= 1'b1;
            busy  <= 1'b0;
            if (accept) begin
              buffer[6'd63] <= bus.i_byte;
              idx           <= 7'd1;
              bitcnt        <= LEN_W'(8);
              busy          <= 1'b1;
              if (bus.i_eom) begin
                eom_seen <= 1'b1;
                ready    <= 1'b0;
                state    <= PAD;
              end else begin
                state <= FILL;
              end
            end else if (bus.i_eom) begin
              eom_seen <= 1'b1;
              busy     <= 1'b1;
              ready    <= 1'b0;
              state    <= PAD;
            end
          end

          FILL: begin
            if (bus.i_eom) eom_seen <= 1'b1;
            if (accept) begin
              buffer[wr_sel] <= bus.i_byte;
              idx            <= idx + 7'd1;
              bitcnt         <= bitcnt + LEN_W'(8);
              if (idx == 7'd63) state <= SEND;
              else if (bus.i_eom) state <= PAD;
              else ready <= 1'b1;
            end else if (bus.i_eom) begin
              state <= PAD;
            end else begin
              ready <= 1'b1;
            end
          end

          PAD: begin
            buffer[wr_sel] <= pad80_done ? 8'h00 : 8'h80;
            pad80_done     <= 1'b1;
            idx            <= idx + 7'd1;
            if (idx == 7'd55) state <= LEN;
            else if (idx == 7'd63) state <= SEND;
          end

          LEN: begin
            buffer[7:0] <= 64'(bitcnt);
            last        <= 1'b1;
            state       <= SEND;
          end

          SEND: begin
            core_start <= 1'b1;
            core_init  <= first;
            first      <= 1'b0;
            state      <= WAIT;
          end

          WAIT: begin
            if (bus.i_core_done) begin
              if (last) begin
                msg_done <= 1'b1;
                state    <= DONE;
              end else begin
                idx <= '0;
                if (eom_seen) begin
                  state <= PAD;
                end else begin
                  ready <= 1'b1;
                  state <= FILL;
                end
              end
            end
          end

          DONE: begin
            idx        <= '0;
            bitcnt     <= '0;
            first      <= 1'b1;
            eom_seen   <= 1'b0;
            last       <= 1'b0;
            pad80_done <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b1;
            state      <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// tb/tb_sha256_msg_ctrl.sv - directed bench for sha256_msg_ctrl with a stub compression core
module tb_sha256_msg_ctrl;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {8'h80, 440'h0, 64'h0};
  localparam logic [511:0] L55_BLK   = {{55{8'h41}}, 8'h80, 64'h1B8};
  localparam logic [511:0] L56_BLK0  = {{56{8'h41}}, 8'h80, 56'h0};
  localparam logic [511:0] L56_BLK1  = {448'h0, 64'h1C0};
  localparam logic [511:0] L64_BLK0  = {64{8'h5A}};
  localparam logic [511:0] L64_BLK1  = {8'h80, 440'h0, 64'h200};

  logic clk;
  logic rst;
  sha256_msg_ctrl_if bus();

  sha256_msg_ctrl #(.LEN_W(64)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cyc = 0;
  int msg_cyc = 0;
  int done_cnt = 0;
  int stalls = 0;
  logic core_auto = 1'b1;
  logic [511:0] blk_q[$];
  logic init_q[$];
  logic [7:0] msg[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every block issued to the core and every message completion.
  always @(negedge clk) begin
    if (bus.o_core_start) begin
      blk_q.push_back(bus.o_blk);
      init_q.push_back(bus.o_core_init);
    end
    if (bus.o_msg_done) begin
      done_cnt++;
      msg_cyc = cyc;
    end
  end

  // Stub core: answers each start with a done pulse a few cycles later.
  initial begin
    bus.i_core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_core_start && core_auto) begin
        repeat (3) @(negedge clk);
        bus.i_core_done = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        bus.i_core_done = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] get_blk(input int i);
    if (i < blk_q.size()) return blk_q[i];
    return '0;
  endfunction

  function automatic logic get_init(input int i);
    if (i < init_q.size()) return init_q[i];
    return 1'bx;
  endfunction

  task automatic send_msg();
    int t;
    if (msg.size() == 0) begin
      bus.i_valid = 1'b0;
      bus.i_eom   = 1'b1;
      t = 0;
      while (!bus.o_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) stalls++;
      @(negedge clk);
    end
    for (int i = 0; i < msg.size(); i++) begin
      bus.i_byte  = msg[i];
      bus.i_valid = 1'b1;
      bus.i_eom   = (i == msg.size() - 1);
      t = 0;
      while (!bus.o_ready && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) stalls++;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    bus.i_eom   = 1'b0;
  endtask

  task automatic wait_done(output int ready_hi, output int timed_out);
    int t;
    t = 0;
    ready_hi = 0;
    while (!bus.o_msg_done && t < 3000) begin
      if (bus.o_ready) ready_hi++;
      @(negedge clk);
      t++;
    end
    timed_out = 0;
    if (t >= 3000) timed_out = 1;
    @(negedge clk);
  endtask

  task automatic run_msg(input string tag, input int nblk,
                         input logic [511:0] exp0, input logic [511:0] exp1);
    int rh, to, d0;
    blk_q.delete();
    init_q.delete();
    stalls = 0;
    d0 = done_cnt;
    send_msg();
    wait_done(rh, to);
    chk({tag, "_timeout"}, 512'(to), 512'(0));
    chk({tag, "_stall"}, 512'(stalls), 512'(0));
    chk({tag, "_starts"}, 512'(blk_q.size()), 512'(nblk));
    chk({tag, "_blk0"}, get_blk(0), exp0);
    chk({tag, "_init0"}, 512'(get_init(0)), 512'(1));
    if (nblk > 1) begin
      chk({tag, "_blk1"}, get_blk(1), exp1);
      chk({tag, "_init1"}, 512'(get_init(1)), 512'(0));
    end
    chk({tag, "_msg_done"}, 512'(done_cnt - d0), 512'(1));
    chk({tag, "_done_lat"}, 512'(msg_cyc - done_cyc), 512'(1));
    chk({tag, "_ready_low"}, 512'(rh), 512'(0));
  endtask

  initial begin
    int t, d0;
    rst         = 1'b1;
    bus.i_byte  = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_eom   = 1'b0;
`ifdef SHA256_MSG_CTRL_ABORT_EN
    bus.i_abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", 512'(bus.o_ready), 512'(0));
    chk("rst_busy", 512'(bus.o_busy), 512'(0));
    chk("rst_start", 512'(bus.o_core_start), 512'(0));
    chk("rst_init", 512'(bus.o_core_init), 512'(0));
    chk("rst_msg_done", 512'(bus.o_msg_done), 512'(0));
    chk("rst_blk", bus.o_blk, 512'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", 512'(bus.o_ready), 512'(1));
    chk("idle_busy", 512'(bus.o_busy), 512'(0));

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg("abc", 1, ABC_BLK, '0);

    msg.delete();
    run_msg("empty", 1, EMPTY_BLK, '0);

    msg.delete();
    for (int i = 0; i < 55; i++) msg.push_back(8'h41);
    run_msg("len55", 1, L55_BLK, '0);

    msg.delete();
    for (int i = 0; i < 56; i++) msg.push_back(8'h41);
    run_msg("len56", 2, L56_BLK0, L56_BLK1);

    msg.delete();
    for (int i = 0; i < 64; i++) msg.push_back(8'h5A);
    run_msg("len64", 2, L64_BLK0, L64_BLK1);
    chk("len64_idle_ready", 512'(bus.o_ready), 512'(1));

    // Reset while the core holds the first block of a two-block message.
    core_auto = 1'b0;
    msg.delete();
    for (int i = 0; i < 60; i++) msg.push_back(8'h33);
    blk_q.delete();
    init_q.delete();
    d0 = done_cnt;
    send_msg();
    t = 0;
    while (blk_q.size() == 0 && t < 500) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("mid_starts", 512'(blk_q.size()), 512'(1));
    chk("mid_busy", 512'(bus.o_busy), 512'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 512'(bus.o_busy), 512'(0));
    chk("mid_rst_start", 512'(bus.o_core_start), 512'(0));
    rst = 1'b0;
    core_auto = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_no_msg_done", 512'(done_cnt - d0), 512'(0));
    chk("mid_ready", 512'(bus.o_ready), 512'(1));

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_msg("abc_after_rst", 1, ABC_BLK, '0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
